// File: rtl/hvsync_generator.sv
// Raster timing generator: pixel/line counters, sync pulses, display-active flag.
// Optional HVSYNC_NEG_SYNC_EN makes hsync/vsync active-low; timing unchanged.
module hvsync_generator #(
    parameter int H_DISPLAY = 256,
    parameter int H_FRONT   = 7,
    parameter int H_SYNC    = 23,
    parameter int H_BACK    = 23,
    parameter int V_DISPLAY = 240,
    parameter int V_BOTTOM  = 14,
    parameter int V_SYNC    = 3,
    parameter int V_TOP     = 5
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [8:0] hpos,
    output logic [8:0] vpos
);

    localparam logic [8:0] H_MAX    = 9'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [8:0] HS_START = 9'(H_DISPLAY + H_FRONT);
    localparam logic [8:0] HS_END   = 9'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [8:0] V_MAX    = 9'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);
    localparam logic [8:0] VS_START = 9'(V_DISPLAY + V_BOTTOM);
    localparam logic [8:0] VS_END   = 9'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
    localparam logic [8:0] H_VIS    = 9'(H_DISPLAY);
    localparam logic [8:0] V_VIS    = 9'(V_DISPLAY);

`ifdef HVSYNC_NEG_SYNC_EN
    localparam logic SYNC_IDLE = 1'b1;
`else
    localparam logic SYNC_IDLE = 1'b0;
`endif

    logic [8:0] hpos_q, hpos_d;
    logic [8:0] vpos_q, vpos_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       h_end;
    logic       hs_act;
    logic       vs_act;

    // Next-state for counters and sync; sync is judged on the pre-edge position
    always_comb begin
        hpos_d  = hpos_q + 9'd1;
        vpos_d  = vpos_q;
        h_end   = (hpos_q == H_MAX);
        hs_act  = (hpos_q >= HS_START) && (hpos_q <= HS_END);
        vs_act  = (vpos_q >= VS_START) && (vpos_q <= VS_END);
        if (h_end) begin
            hpos_d = 9'd0;
            if (vpos_q == V_MAX) begin
                vpos_d = 9'd0;
            end else begin
                vpos_d = vpos_q + 9'd1;
            end
        end
        hsync_d = hs_act ^ SYNC_IDLE;
        vsync_d = vs_act ^ SYNC_IDLE;
    end

    // Raster state registers, cleared asynchronously to the top-left corner
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hpos_q  <= 9'd0;
            vpos_q  <= 9'd0;
            hsync_q <= SYNC_IDLE;
            vsync_q <= SYNC_IDLE;
        end else begin
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign hpos       = hpos_q;
    assign vpos       = vpos_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign display_on = (hpos_q < H_VIS) && (vpos_q < V_VIS);

endmodule

// File: tb/tb_hvsync_generator.sv
// Directed self-checking bench for hvsync_generator.
// Walks the first frame, checks wrap points, then an async reset mid-frame.
module tb_hvsync_generator;

`ifdef HVSYNC_NEG_SYNC_EN
    localparam logic SON = 1'b0;
`else
    localparam logic SON = 1'b1;
`endif
    localparam logic SOFF = ~SON;

    logic       clk;
    logic       reset;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic [8:0] hpos;
    logic [8:0] vpos;

    int n_chk;
    int n_fail;
    int cyc;
    int vs_cnt;
    int hs_cnt;
    int de_cnt;
    int de_bad;
    int pos_bad;

    hvsync_generator dut (
        .clk        (clk),
        .reset      (reset),
        .hsync      (hsync),
        .vsync      (vsync),
        .display_on (display_on),
        .hpos       (hpos),
        .vpos       (vpos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock per iteration, sampled 1 time unit after the edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (vsync === SON) vs_cnt++;
            if (hsync === SON) hs_cnt++;
            if (display_on === 1'b1) de_cnt++;
            if (vpos >= 9'd240 && display_on !== 1'b0) de_bad++;
            if (int'(hpos) != cyc % 309 || int'(vpos) != (cyc / 309) % 262)
                pos_bad++;
        end
    endtask

    task automatic step_to(input int target);
        step(target - cyc);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        cyc     = 0;
        vs_cnt  = 0;
        hs_cnt  = 0;
        de_cnt  = 0;
        de_bad  = 0;
        pos_bad = 0;
        reset   = 1'b0;

        repeat (5) @(negedge clk);
        check_eq("rst_hpos", hpos, 0);
        check_eq("rst_vpos", vpos, 0);
        check_eq("rst_hsync", hsync, SOFF);
        check_eq("rst_vsync", vsync, SOFF);
        check_eq("rst_de", display_on, 1);
        reset = 1'b1;

        step(1);
        check_eq("first_hpos", hpos, 1);
        check_eq("first_vpos", vpos, 0);

        step_to(308);
        check_eq("eol_hpos", hpos, 308);
        check_eq("eol_vpos", vpos, 0);
        check_eq("eol_de", display_on, 0);
        step(1);
        check_eq("wrap_hpos", hpos, 0);
        check_eq("wrap_vpos", vpos, 1);

        step_to(309 + 255);
        check_eq("de_255", display_on, 1);
        step(1);
        check_eq("de_256", display_on, 0);

        step_to(309 + 263);
        check_eq("hs_at263", hsync, SOFF);
        step(1);
        check_eq("hs_at264", hsync, SON);
        step_to(309 + 286);
        check_eq("hs_at286", hsync, SON);
        step(1);
        check_eq("hs_at287", hsync, SOFF);

        step_to(2 * 309 - 1);
        hs_cnt = 0;
        step(309);
        check_eq("hs_per_line", hs_cnt, 23);

        step_to(240 * 309);
        check_eq("de_v240", display_on, 0);

        step_to(254 * 309);
        check_eq("vs_at254_0", vsync, SOFF);
        step(1);
        check_eq("vs_at254_1", vsync, SON);

        step_to(80957);
        check_eq("eof_hpos", hpos, 308);
        check_eq("eof_vpos", vpos, 261);
        step(1);
        check_eq("fwrap_hpos", hpos, 0);
        check_eq("fwrap_vpos", vpos, 0);
        check_eq("vs_per_frame", vs_cnt, 927);
        check_eq("de_per_frame", de_cnt, 61440);
        check_eq("de_blank_rows", de_bad, 0);
        check_eq("pos_track", pos_bad, 0);

        step_to(80958 + 50 * 309 + 100);
        check_eq("pre_ar_hpos", hpos, 100);
        check_eq("pre_ar_vpos", vpos, 50);
        reset = 1'b0;
        #1;
        check_eq("ar_hpos", hpos, 0);
        check_eq("ar_vpos", vpos, 0);
        check_eq("ar_hsync", hsync, SOFF);
        check_eq("ar_vsync", vsync, SOFF);
        check_eq("ar_de", display_on, 1);
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        pos_bad = 0;
        step(1);
        check_eq("rel_hpos", hpos, 1);
        check_eq("rel_vpos", vpos, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
